// File: rtl/setup_pkg.sv
// Shared types and default widths for the systolic-array data-setup unit and its tile scheduler.
package setup_pkg;

    localparam int unsigned SETUP_TILE_W    = 8;
    localparam int unsigned SETUP_BURST_W   = 11;
    localparam int unsigned SETUP_DRAIN_CYC = 25;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        FINISH
    } sched_state_t;

endpackage

// File: rtl/setup_perf_cnt.sv
// Saturating 32-bit event counter with synchronous clear; used for scheduler performance stats.
module setup_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 32'd1;
        end
    end

endmodule

// File: rtl/setup_tile_sched.sv
// Tile scheduler: per tile, weight load -> burst stream -> fixed drain; reports done after all tiles.
// Optional perf counters on STREAM / LOAD_W cycles are built when SETUP_SCHED_PERF_EN is defined.
module setup_tile_sched
    import setup_pkg::*;
#(
    parameter int unsigned TILE_W    = SETUP_TILE_W,
    parameter int unsigned BURST_W   = SETUP_BURST_W,
    parameter int unsigned DRAIN_CYC = SETUP_DRAIN_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [BURST_W-1:0] cfg_burst_i,
    input  logic [TILE_W-1:0]  cfg_tiles_i,
    output logic               wload_req_o,
    input  logic               wload_done_i,
    output logic [BURST_W-1:0] burst_size_o,
    output logic               weight_ready_o,
    input  logic               burst_last_i,
    output logic [TILE_W-1:0]  tile_idx_o,
    output logic               busy_o,
`ifdef SETUP_SCHED_PERF_EN
    output logic [31:0]        perf_stream_cyc_o,
    output logic [31:0]        perf_wait_cyc_o,
`endif
    output logic               done_o
);

    localparam int unsigned CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);

    sched_state_t      state_q;
    logic [TILE_W-1:0] tiles_q;
    logic [CNT_W-1:0]  drain_q;
    logic              last_tile;

    // Zero tiles never reaches DRAIN, so tiles_q - 1 cannot wrap here.
    assign last_tile = (tile_idx_o == (tiles_q - TILE_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            tiles_q        <= '0;
            drain_q        <= '0;
            burst_size_o   <= '0;
            tile_idx_o     <= '0;
            wload_req_o    <= 1'b0;
            weight_ready_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else if (abort_i) begin
            // burst_size_o is kept: it only changes on an accepted start.
            state_q        <= IDLE;
            drain_q        <= '0;
            tile_idx_o     <= '0;
            wload_req_o    <= 1'b0;
            weight_ready_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        burst_size_o <= cfg_burst_i;
                        tiles_q      <= cfg_tiles_i;
                        tile_idx_o   <= '0;
                        busy_o       <= 1'b1;
                        if ((cfg_tiles_i == '0) || (cfg_burst_i == '0)) begin
                            state_q <= FINISH;
                        end else begin
                            state_q     <= LOAD_W;
                            wload_req_o <= 1'b1;
                        end
                    end
                end
                LOAD_W: begin
                    if (wload_done_i) begin
                        wload_req_o    <= 1'b0;
                        weight_ready_o <= 1'b1;
                        state_q        <= STREAM;
                    end
                end
                STREAM: begin
                    if (burst_last_i) begin
                        weight_ready_o <= 1'b0;
                        drain_q        <= DRAIN_LOAD;
                        state_q        <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        if (last_tile) begin
                            state_q <= FINISH;
                        end else begin
                            tile_idx_o  <= tile_idx_o + TILE_W'(1);
                            wload_req_o <= 1'b1;
                            state_q     <= LOAD_W;
                        end
                    end else begin
                        drain_q <= drain_q - CNT_W'(1);
                    end
                end
                FINISH: begin
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SETUP_SCHED_PERF_EN
    logic perf_clr;
    logic perf_in_stream;
    logic perf_in_wait;

    assign perf_clr       = (state_q == IDLE) && start_i && !abort_i;
    assign perf_in_stream = (state_q == STREAM);
    assign perf_in_wait   = (state_q == LOAD_W);

    setup_perf_cnt u_perf_stream (
        .clk   (clk),
        .rst   (rst),
        .clr_i (perf_clr),
        .inc_i (perf_in_stream),
        .cnt_o (perf_stream_cyc_o)
    );

    setup_perf_cnt u_perf_wait (
        .clk   (clk),
        .rst   (rst),
        .clr_i (perf_clr),
        .inc_i (perf_in_wait),
        .cnt_o (perf_wait_cyc_o)
    );
`endif

endmodule

// File: tb/tb_setup_tile_sched.sv
// Bench for setup_tile_sched: per-cycle expected outputs are built from a phase-level plan
// (load / stream / drain lengths per tile) and compared after every clock edge.
module tb_setup_tile_sched;

    logic        clk = 1'b0;
    logic        rst, start_i, abort_i, wload_done_i, burst_last_i;
    logic [10:0] cfg_burst_i;
    logic [7:0]  cfg_tiles_i;
    logic        wload_req_o, weight_ready_o, busy_o, done_o;
    logic [10:0] burst_size_o;
    logic [7:0]  tile_idx_o;
`ifdef SETUP_SCHED_PERF_EN
    logic [31:0] perf_stream_cyc_o, perf_wait_cyc_o;
`endif

    always #5 clk = ~clk;

    setup_tile_sched dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .cfg_burst_i    (cfg_burst_i),
        .cfg_tiles_i    (cfg_tiles_i),
        .wload_req_o    (wload_req_o),
        .wload_done_i   (wload_done_i),
        .burst_size_o   (burst_size_o),
        .weight_ready_o (weight_ready_o),
        .burst_last_i   (burst_last_i),
        .tile_idx_o     (tile_idx_o),
        .busy_o         (busy_o),
`ifdef SETUP_SCHED_PERF_EN
        .perf_stream_cyc_o (perf_stream_cyc_o),
        .perf_wait_cyc_o   (perf_wait_cyc_o),
`endif
        .done_o         (done_o)
    );

    typedef struct packed {
        logic rst, abort, start, wdone, last;
        logic [10:0] cb;
        logic [7:0]  ct;
    } stim_t;

    typedef struct packed {
        logic req, ready, busy, done;
        logic [10:0] burst;
        logic [7:0]  idx;
    } obs_t;

    typedef struct {
        stim_t s;
        obs_t  e;
        bit    chk_idx;
    } ent_t;

    ent_t        plan[$];
    logic [10:0] model_burst;
    int          stream0_idx, drain1_idx, run_start_idx;
    int          sum_lw, sum_ls;
    int          vectors = 0;
    int          errors = 0;
    int          lw[4], ls[4];

    function automatic obs_t mk(bit req, bit rdy, bit busy, bit done, int idx);
        obs_t o;
        o.req = req; o.ready = rdy; o.busy = busy; o.done = done;
        o.burst = model_burst; o.idx = 8'(idx);
        return o;
    endfunction

    function automatic void push(stim_t s, obs_t e, bit chk);
        ent_t x;
        x.s = s; x.e = e; x.chk_idx = chk;
        plan.push_back(x);
    endfunction

    // Background noise that the scheduler must ignore in the current phase.
    function automatic stim_t filler(bit spur, bit allow_w, bit allow_l);
        stim_t r = '0;
        if (spur) begin
            r.start = ($urandom_range(0, 3) == 0);
            r.cb    = 11'($urandom);
            r.ct    = 8'($urandom);
            r.wdone = allow_w && ($urandom_range(0, 2) == 0);
            r.last  = allow_l && ($urandom_range(0, 2) == 0);
        end
        return r;
    endfunction

    function automatic void build_run(int tiles, int burst, bit spur);
        stim_t s0 = '0;
        stim_t q;
        s0.start = 1'b1; s0.cb = 11'(burst); s0.ct = 8'(tiles);
        run_start_idx = plan.size();
        model_burst = 11'(burst);
        sum_lw = 0; sum_ls = 0;
        if (tiles == 0 || burst == 0) begin
            push(s0, mk(0, 0, 1, 0, 0), 0);
            push('0, mk(0, 0, 0, 1, 0), 0);
            push('0, mk(0, 0, 0, 0, 0), 0);
            return;
        end
        push(s0, mk(1, 0, 1, 0, 0), 1);
        for (int t = 0; t < tiles; t++) begin
            sum_lw += lw[t]; sum_ls += ls[t];
            for (int j = 1; j < lw[t]; j++) push(filler(spur, 0, 1), mk(1, 0, 1, 0, t), 1);
            q = '0; q.wdone = 1'b1;
            if (t == 0) stream0_idx = plan.size();
            push(q, mk(0, 1, 1, 0, t), 1);
            for (int j = 1; j < ls[t]; j++) push(filler(spur, 1, 0), mk(0, 1, 1, 0, t), 1);
            q = '0; q.last = 1'b1;
            if (t == 1) drain1_idx = plan.size();
            push(q, mk(0, 0, 1, 0, t), 1);
            for (int j = 1; j < 25; j++) push(filler(spur, 1, 1), mk(0, 0, 1, 0, t), 1);
            if (t < tiles - 1) push('0, mk(1, 0, 1, 0, t + 1), 1);
            else               push('0, mk(0, 0, 1, 0, t), 1);
        end
        push('0, mk(0, 0, 0, 1, 0), 0);
        push('0, mk(0, 0, 0, 0, 0), 0);
    endfunction

    // Replace entry k by an abort or reset and drop everything after it.
    function automatic void cut(int k, bit use_rst, logic [10:0] prev_burst);
        while (plan.size() > k + 1) void'(plan.pop_back());
        plan[k].s.abort = !use_rst;
        plan[k].s.rst   = use_rst;
        if (use_rst) model_burst = '0;
        else if (k == run_start_idx) model_burst = prev_burst;
        plan[k].e = mk(0, 0, 0, 0, 0);
        plan[k].chk_idx = 1;
        push('0, mk(0, 0, 0, 0, 0), 1);
        push('0, mk(0, 0, 0, 0, 0), 1);
    endfunction

    task automatic drive(stim_t s);
        rst = s.rst; abort_i = s.abort; start_i = s.start;
        wload_done_i = s.wdone; burst_last_i = s.last;
        cfg_burst_i = s.cb; cfg_tiles_i = s.ct;
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t sample(bit chk);
        obs_t o;
        o.req = wload_req_o; o.ready = weight_ready_o; o.busy = busy_o; o.done = done_o;
        o.burst = burst_size_o; o.idx = chk ? tile_idx_o : 8'd0;
        return o;
    endfunction

    task automatic test_reset();
        stim_t s = '0;
        obs_t  got;
        s.rst = 1'b1;
        model_burst = '0;
        for (int i = 0; i < 3; i++) begin
            drive(s);
            got = sample(1);
            vectors++;
            if (got !== mk(0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL reset[%0d] got %h want %h", i, got, mk(0, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_basic(string name, bit spur);
        obs_t got;
        plan.delete();
        lw[0] = 4; lw[1] = 4; ls[0] = 41; ls[1] = 41;
        build_run(2, 16, spur);
        foreach (plan[i]) begin
            drive(plan[i].s);
            got = sample(plan[i].chk_idx);
            vectors++;
            if (got !== plan[i].e) begin
                errors++;
                $display("FAIL %s[%0d] got %h want %h", name, i, got, plan[i].e);
            end
        end
`ifdef SETUP_SCHED_PERF_EN
        vectors++;
        if (perf_wait_cyc_o !== 32'd8 || perf_stream_cyc_o !== 32'd82) begin
            errors++;
            $display("FAIL %s_perf got wait=%0d stream=%0d want 8 82", name,
                     perf_wait_cyc_o, perf_stream_cyc_o);
        end
`endif
    endtask

    task automatic test_random();
        obs_t got;
        for (int it = 0; it < 5; it++) begin
            plan.delete();
            for (int t = 0; t < 4; t++) begin
                lw[t] = $urandom_range(1, 6);
                ls[t] = $urandom_range(1, 12);
            end
            build_run($urandom_range(1, 4), $urandom_range(1, 2047), 1'($urandom));
            foreach (plan[i]) begin
                drive(plan[i].s);
                got = sample(plan[i].chk_idx);
                vectors++;
                if (got !== plan[i].e) begin
                    errors++;
                    $display("FAIL random%0d[%0d] got %h want %h", it, i, got, plan[i].e);
                end
            end
`ifdef SETUP_SCHED_PERF_EN
            vectors++;
            if (perf_wait_cyc_o !== 32'(sum_lw) || perf_stream_cyc_o !== 32'(sum_ls)) begin
                errors++;
                $display("FAIL random%0d_perf got wait=%0d stream=%0d want %0d %0d", it,
                         perf_wait_cyc_o, perf_stream_cyc_o, sum_lw, sum_ls);
            end
`endif
        end
    endtask

    task automatic test_zero();
        obs_t got;
        plan.delete();
        build_run(0, 37, 0);
        build_run(3, 0, 0);
        foreach (plan[i]) begin
            drive(plan[i].s);
            got = sample(plan[i].chk_idx);
            vectors++;
            if (got !== plan[i].e) begin
                errors++;
                $display("FAIL zero[%0d] got %h want %h", i, got, plan[i].e);
            end
        end
    endtask

    task automatic test_abort();
        obs_t        got;
        logic [10:0] prev;
        plan.delete();
        for (int t = 0; t < 4; t++) begin lw[t] = $urandom_range(1, 4); ls[t] = 6; end
        // Mid-stream abort, then a fresh run.
        prev = model_burst;
        build_run(2, 100, 0);
        cut(stream0_idx + $urandom_range(1, 4), 0, prev);
        build_run(1, 200, 0);
        // Abort together with start: the start must be dropped.
        prev = model_burst;
        build_run(2, 300, 0);
        cut(run_start_idx, 0, prev);
        build_run(1, 400, 0);
        // Abort at an arbitrary point, including the FINISH cycle.
        prev = model_burst;
        build_run(2, 500, 1);
        cut(run_start_idx + $urandom_range(1, plan.size() - run_start_idx - 2), 0, prev);
        prev = model_burst;
        build_run(1, 600, 0);
        cut(plan.size() - 2, 0, prev);
        build_run(1, 700, 0);
        foreach (plan[i]) begin
            drive(plan[i].s);
            got = sample(plan[i].chk_idx);
            vectors++;
            if (got !== plan[i].e) begin
                errors++;
                $display("FAIL abort[%0d] got %h want %h", i, got, plan[i].e);
            end
        end
    endtask

    task automatic test_rst_mid();
        obs_t got;
        plan.delete();
        for (int t = 0; t < 4; t++) begin lw[t] = 3; ls[t] = 5; end
        build_run(2, 64, 0);
        cut(drain1_idx + $urandom_range(1, 24), 1, model_burst);
        build_run(2, 65, 0);
        foreach (plan[i]) begin
            drive(plan[i].s);
            got = sample(plan[i].chk_idx);
            vectors++;
            if (got !== plan[i].e) begin
                errors++;
                $display("FAIL rst_mid[%0d] got %h want %h", i, got, plan[i].e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; wload_done_i = 1'b0; burst_last_i = 1'b0;
        cfg_burst_i = '0; cfg_tiles_i = '0;
        test_reset();
        test_basic("basic", 0);
        test_basic("spurious", 1);
        test_random();
        test_zero();
        test_abort();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
